// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control slice.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Contents: opcode values, ALUOp / ALU source B / PC source encodings,
//           4-bit control FSM state enum, opcode classification helper.
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  // ALUOp to the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  // ALU source B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXEC_R   = 4'd7,
    WB_R     = 4'd8,
    EXEC_I   = 4'd9,
    WB_I     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    HALT     = 4'd13
  } state_t;

  // I-type ALU instructions handled by the EXEC_I / WB_I path
  function automatic logic is_itype_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multicycle main control and the datapath/memory.
// Latency: n/a (wiring only).
// Backpressure: mem_ready from memory stalls the controller in its access states.
// master: the control FSM (drives the datapath controls, reads opcode/mem_ready/zero).
// slave:  the datapath + memory side.
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, mem_ready, zero,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout, state_dbg
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout, state_dbg
  );
endinterface

// File: rtl/mips_mc_watchdog.sv
// Memory-access watchdog: counts unanswered cycles of the current access, flags a sticky fault.
// Latency: timeout is combinational in the cycle the count reaches the limit; fault registers on that edge.
// Backpressure: none; it only observes mem_ready.
// Ports: clk, rst_n; wait_st (controller is in an access state), mem_ready;
//        timeout (abandon the access now), fault (sticky until reset).
module mips_mc_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_st,
  input  logic mem_ready,
  output logic timeout,
  output logic fault
);

  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;

  // This cycle is the TIMEOUT_CYCLES-th unanswered one; a ready in the same
  // cycle means the access completed, so ready suppresses the fault.
  assign timeout = wait_st && !mem_ready && (cnt_q == LIMIT_M1);

  // Each access state is left as soon as mem_ready arrives and access states
  // are never back-to-back without completion, so clearing whenever we are
  // not waiting is the same as clearing on entry to an access state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      fault <= 1'b0;
    end else begin
      if (wait_st && !mem_ready) cnt_q <= cnt_q + 8'd1;
      else                       cnt_q <= 8'd0;
      if (timeout) fault <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/write-back.
// Latency: one state per cycle; lw 5, sw 4, R/I 4, beq 3, j 3 cycles plus memory wait cycles.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready; watchdog abandons to HALT.
// Ports: clk, rst_n (async, active-low); bus (master modport): opcode, mem_ready, zero in;
//        datapath enables, alu_src_b, alu_op, pc_source, illegal_op, mem_timeout, state_dbg out.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_mc_control_if.master   bus
);

  state_t state_q, state_d;
  logic   wd_timeout, wd_fault, wait_st;

  // zero is consumed by the datapath together with pc_write_cond
  logic unused_zero;
  assign unused_zero = bus.zero;

  assign wait_st = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);

  mips_mc_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .wait_st   (wait_st),
    .mem_ready (bus.mem_ready),
    .timeout   (wd_timeout),
    .fault     (wd_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign bus.state_dbg   = state_q;
  assign bus.mem_timeout = wd_fault;

  always_comb begin
    state_d           = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.alu_op        = ALUOP_ADD;
    bus.pc_source     = PCSRC_ALU;
    bus.illegal_op    = 1'b0;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        // IR load and PC+4 only happen on the cycle the instruction arrives
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = DECODE;
        end else if (wd_timeout) begin
          state_d = HALT;
        end
      end

      DECODE: begin
        // ALUOut <= PC + (imm << 2): branch target ready for BRANCH
        bus.alu_src_b = SRCB_IMM_SH2;
        if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) state_d = MEMADR;
        else if (bus.opcode == OP_R)                        state_d = EXEC_R;
        else if (bus.opcode == OP_BEQ)                      state_d = BRANCH;
        else if (bus.opcode == OP_J)                        state_d = JUMP;
        else if (is_itype_alu(bus.opcode))                  state_d = EXEC_I;
        else begin
          bus.illegal_op = 1'b1;
          state_d        = FETCH;
        end
      end

      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end

      MEMREAD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready)   state_d = MEMWB;
        else if (wd_timeout) state_d = HALT;
      end

      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end

      MEMWRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready)   state_d = FETCH;
        else if (wd_timeout) state_d = HALT;
      end

      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_FUNCT;
        state_d       = WB_R;
      end

      WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = FETCH;
      end

      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        // ALU control picks ADD/AND/OR/XOR from the opcode; only SLTI needs a compare
        bus.alu_op    = (bus.opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
        state_d       = WB_I;
      end

      WB_I: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end

      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        state_d           = FETCH;
      end

      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
        state_d       = FETCH;
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control with an instruction-level trace model.
// Latency: n/a.
// Backpressure: the bench plays the memory, choosing mem_ready wait counts per access.
module tb_mips_mc_control;
  import mips_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctl_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mips_mc_control_if bus();

  mips_mc_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.pc_write      = bus.pc_write;
    c.pc_write_cond = bus.pc_write_cond;
    c.iord          = bus.iord;
    c.mem_read      = bus.mem_read;
    c.mem_write     = bus.mem_write;
    c.ir_write      = bus.ir_write;
    c.mem_to_reg    = bus.mem_to_reg;
    c.reg_dst       = bus.reg_dst;
    c.reg_write     = bus.reg_write;
    c.alu_src_a     = bus.alu_src_a;
    c.alu_src_b     = bus.alu_src_b;
    c.alu_op        = bus.alu_op;
    c.pc_source     = bus.pc_source;
    c.illegal_op    = bus.illegal_op;
    c.mem_timeout   = bus.mem_timeout;
    return c;
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                     6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
  endfunction

  // Control outputs each state must show, straight from the state descriptions
  function automatic ctl_t exp_ctl(input state_t st, input logic rdy, input logic [5:0] opc);
    ctl_t c = '0;
    case (st)
      FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      DECODE:   begin c.alu_src_b = 2'b11; c.illegal_op = !legal(opc); end
      MEMADR:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      MEMREAD:  begin c.mem_read = 1; c.iord = 1; end
      MEMWB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
      MEMWRITE: begin c.mem_write = 1; c.iord = 1; end
      EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      WB_R:     begin c.reg_write = 1; c.reg_dst = 1; end
      EXEC_I:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (opc == 6'b001010) ? 2'b11 : 2'b00; end
      WB_I:     begin c.reg_write = 1; end
      BRANCH:   begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      JUMP:     begin c.pc_write = 1; c.pc_source = 2'b10; end
      HALT:     begin c.mem_timeout = 1; end
      default:  ;
    endcase
    return c;
  endfunction

  // Expected cycle trace: state, mem_ready to drive, opcode to drive
  state_t     q_st[$];
  logic       q_rdy[$];
  logic [5:0] q_opc[$];
  bit         halted;

  task automatic add(input state_t s, input logic r, input logic [5:0] o);
    q_st.push_back(s);
    q_rdy.push_back(r);
    q_opc.push_back(o);
  endtask

  // A memory access answered after w unanswered cycles; the TO-th unanswered
  // cycle abandons it.
  task automatic access(input state_t s, input int w, input logic [5:0] o);
    for (int i = 0; i < w; i++) begin
      add(s, 1'b0, o);
      if (i == TO - 1) begin
        halted = 1;
        repeat (3) add(HALT, 1'($urandom), o);
        return;
      end
    end
    add(s, 1'b1, o);
  endtask

  task automatic instr(input logic [5:0] o, input int wf, input int wm);
    if (halted) return;
    access(FETCH, wf, o);
    if (halted) return;
    add(DECODE, 1'($urandom), o);
    case (o)
      6'b100011: begin add(MEMADR, 1'($urandom), o); access(MEMREAD, wm, o);
                       if (!halted) add(MEMWB, 1'($urandom), o); end
      6'b101011: begin add(MEMADR, 1'($urandom), o); access(MEMWRITE, wm, o); end
      6'b000000: begin add(EXEC_R, 1'($urandom), o); add(WB_R, 1'($urandom), o); end
      6'b000100: add(BRANCH, 1'($urandom), o);
      6'b000010: add(JUMP, 1'($urandom), o);
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010:
                 begin add(EXEC_I, 1'($urandom), o); add(WB_I, 1'($urandom), o); end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    #3;
    chk("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    chk("rst_ctl", 32'(dut_ctl()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q_st.delete();
    q_rdy.delete();
    q_opc.delete();
    halted = 0;
    add(IDLE, 1'b0, 6'd0);
  endtask

  // Plays the trace from reset release (posedge + 1). With use_stop, returns
  // mid-cycle right after checking the first cycle whose state is stop_st.
  task automatic run(input bit use_stop, input state_t stop_st);
    for (int k = 0; k < q_st.size(); k++) begin
      bus.mem_ready = q_rdy[k];
      bus.opcode    = q_opc[k];
      bus.zero      = 1'($urandom);
      #3;
      chk($sformatf("state@%0d", k), 32'(bus.state_dbg), 32'(q_st[k]));
      chk($sformatf("ctl@%0d(%s)", k, q_st[k].name()), 32'(dut_ctl()),
          32'(exp_ctl(q_st[k], q_rdy[k], q_opc[k])));
      if (use_stop && q_st[k] == stop_st) return;
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] ops [10];
  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
  end

  initial begin
    logic [5:0] o;

    // R-type with memory always ready
    do_reset();
    instr(6'b000000, 0, 0);
    instr(6'b000000, 0, 0);
    run(0, IDLE);

    // lw with three wait cycles in MEMREAD, then sw, SLTI, XORI, beq, j, illegal
    do_reset();
    instr(6'b100011, 0, 3);
    instr(6'b101011, 1, 2);
    instr(6'b001010, 0, 0);
    instr(6'b001110, 0, 0);
    instr(6'b000100, 2, 0);
    instr(6'b000010, 0, 0);
    instr(6'b111111, 0, 0);
    instr(6'b000000, 3, 0);
    run(0, IDLE);

    // Fetch never answered: HALT with a sticky fault
    do_reset();
    instr(6'b000000, 0, 0);
    instr(6'b000000, 8, 0);
    run(0, IDLE);

    // Load data never answered
    do_reset();
    instr(6'b100011, 0, 9);
    run(0, IDLE);

    // Store never answered
    do_reset();
    instr(6'b101011, 2, 5);
    run(0, IDLE);

    // Reset asserted in the middle of a MEMWRITE cycle
    do_reset();
    instr(6'b101011, 0, 3);
    run(1, MEMWRITE);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("async_rst_state", 32'(bus.state_dbg), 32'(IDLE));
    chk("async_rst_ctl", 32'(dut_ctl()), 32'd0);

    // Random programs; the last ones allow waits long enough to time out
    for (int p = 0; p < 10; p++) begin
      do_reset();
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          do o = 6'($urandom); while (legal(o));
        end else begin
          o = ops[$urandom_range(0, 9)];
        end
        instr(o, $urandom_range(0, (p < 8) ? 3 : 5), $urandom_range(0, (p < 8) ? 3 : 5));
      end
      run(0, IDLE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case the bench itself stalls
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
